// File: rtl/online_sub_r4_arb.sv
// Scheduler and sequencer for the shared radix-4 online subtractor datapath.
// Picks one of two clients by round-robin and pulses a datapath clear.
// It then streams the client's digits MSD-first, followed by a zero flush digit.
// It collects the N+1 result digits and returns them with a one-cycle done pulse.
// For addition the y digits are negated, so one subtractor covers both operations.
//
// state | meaning
// IDLE  | waiting for a request, arbitration happens here
// CLR   | one-cycle datapath clear
// RUN   | N+1 enabled cycles: N operand digits plus one flush digit
// CAPT  | last result digit captured, datapath disabled
// DONE  | done pulse to the served client, round-robin pointer updated

module online_sub_r4_arb #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         i_req,
    input  logic [1:0]         i_op_sub,
    input  logic [3*N-1:0]     i_x0,
    input  logic [3*N-1:0]     i_y0,
    input  logic [3*N-1:0]     i_x1,
    input  logic [3*N-1:0]     i_y1,
    output logic [1:0]         o_gnt,
    output logic               o_busy,
    output logic [1:0]         o_done,
    output logic [3*(N+1)-1:0] o_result,
    output logic               o_dp_clr,
    output logic               o_dp_en,
    output logic [2:0]         o_dp_x,
    output logic [2:0]         o_dp_y,
    input  logic [2:0]         i_dp_z
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [1:0]            r_gnt;
    logic [1:0]            w_gnt_nxt;
    logic                  r_op_sub;
    logic                  w_op_sub_nxt;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  w_win;

    logic                  r_busy;
    logic [1:0]            r_done;
    logic [3*(N+1)-1:0]    r_result;
    logic                  r_dp_clr;
    logic                  r_dp_en;
    logic [2:0]            r_dp_x;
    logic [2:0]            r_dp_y;

    logic                  w_busy_nxt;
    logic [1:0]            w_done_nxt;
    logic [3*(N+1)-1:0]    w_result_nxt;
    logic                  w_dp_clr_nxt;
    logic                  w_dp_en_nxt;
    logic [2:0]            w_dp_x_nxt;
    logic [2:0]            w_dp_y_nxt;
    logic [3*N-1:0]        w_x_shift;
    logic [3*N-1:0]        w_y_shift;
    logic [2:0]            w_y_dig;
    logic                  w_capt;

    // Round-robin winner: on contention the client not served last wins.
    assign w_win = (i_req == 2'b11) ? ~r_last : i_req[1];

    // State register plus all registered outputs; every output clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_gnt    <= 2'b00;
            r_op_sub <= 1'b0;
            r_last   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 2'b00;
            r_result <= '0;
            r_dp_clr <= 1'b0;
            r_dp_en  <= 1'b0;
            r_dp_x   <= 3'd0;
            r_dp_y   <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_op_sub <= w_op_sub_nxt;
            r_last   <= w_last_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
            r_dp_clr <= w_dp_clr_nxt;
            r_dp_en  <= w_dp_en_nxt;
            r_dp_x   <= w_dp_x_nxt;
            r_dp_y   <= w_dp_y_nxt;
        end
    end

    // Next-state logic: sequencing, grant latch and round-robin pointer.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_gnt_nxt    = r_gnt;
        w_op_sub_nxt = r_op_sub;
        w_last_nxt   = r_last;
        case (r_state)
            S_IDLE: begin
                if (|i_req) begin
                    w_state_nxt  = S_CLR;
                    w_cnt_nxt    = '0;
                    w_gnt_nxt    = w_win ? 2'b10 : 2'b01;
                    w_op_sub_nxt = i_op_sub[w_win];
                end
            end
            S_CLR: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
            S_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_CAPT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CAPT: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
                w_last_nxt  = r_gnt[1];
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

    // Output logic: decode the upcoming state so every output leaves a flop.
    always_comb begin
        w_busy_nxt   = (w_state_nxt != S_IDLE);
        w_done_nxt   = (w_state_nxt == S_DONE) ? w_gnt_nxt : 2'b00;
        w_dp_clr_nxt = (w_state_nxt == S_CLR);
        w_dp_en_nxt  = (w_state_nxt == S_RUN);
        // Shift the selected operand so the digit for this count sits at the top.
        w_x_shift    = (w_gnt_nxt[1] ? i_x1 : i_x0) << (3 * w_cnt_nxt);
        w_y_shift    = (w_gnt_nxt[1] ? i_y1 : i_y0) << (3 * w_cnt_nxt);
        w_y_dig      = w_y_shift[3*N-1 -: 3];
        w_dp_x_nxt   = 3'd0;
        w_dp_y_nxt   = 3'd0;
        if (w_state_nxt == S_RUN && w_cnt_nxt != CNT_LAST) begin
            w_dp_x_nxt = w_x_shift[3*N-1 -: 3];
            // Two's-complement negation; -4 (3'b100) maps onto itself.
            w_dp_y_nxt = w_op_sub_nxt ? w_y_dig : (~w_y_dig + 3'd1);
        end
        // dp_z is valid the cycle after each enabled edge: RUN cnt>=1 and CAPT.
        w_capt       = (r_state == S_RUN && r_cnt != '0) || (r_state == S_CAPT);
        w_result_nxt = w_capt ? {r_result[3*N-1:0], i_dp_z} : r_result;
    end

    assign o_gnt    = r_gnt;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_dp_clr = r_dp_clr;
    assign o_dp_en  = r_dp_en;
    assign o_dp_x   = r_dp_x;
    assign o_dp_y   = r_dp_y;

endmodule
